line_to_word_serializer: RTL and testbench
==========================================

// Module: line_to_word_serializer
// PURPOSE
//  Downstream stage of the 32-bit-to-line coupler. Accepts one LINE_BYTES-wide mem_if request and
//  splits it into WORDS = LINE_BYTES/4 sequential 32-bit accesses on a word-wide backing memory.
//  Read words are assembled into a line buffer and returned as one line response.
//  Lets line-granular clients (cache fill/evict, coupler) run on word-wide BRAM/bus memories.
// PARAMETERS
//  LINE_BYTES    64  bytes per line; power of two, >= 8
//  ADDRESS_SIZE  32  address width in bits
// PORTS
//  clk            in   1              rising-edge clock
//  reset          in   1              asynchronous, active-low; 0 = reset
//  line_addr      in   ADDRESS_SIZE   line address; low $clog2(LINE_BYTES) bits ignored
//  line_data_i    in   8*LINE_BYTES   write data, byte b at bits [8b+7:8b]
//  line_data_en   in   LINE_BYTES     write byte enables
//  line_read_en   in   1              line read request, held until line_done
//  line_write_en  in   1              line write request, held until line_done
//  line_data_o    out  8*LINE_BYTES   assembled read line
//  line_hit       out  1              equals line_done (backing memory always hits)
//  line_done      out  1              one-cycle completion pulse
//  word_addr      out  ADDRESS_SIZE   word address = base + 4*idx
//  word_data_i    out  32             write word = line_data_i slice idx (captured copy)
//  word_data_en   out  4              byte enables for slice idx (writes); 4'hF on reads
//  word_read_en   out  1              word read, held until word_done
//  word_write_en  out  1              word write, held until word_done
//  word_data_o    in   32             read data, valid when word_done = 1
//  word_done      in   1              word access complete; may be high in the issue cycle
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, idx=0, line buffer=0. All outputs 0 immediately.
//  - States: IDLE -> ISSUE -> RESP -> IDLE.
//  - IDLE: if line_write_en|line_read_en at the edge, capture aligned addr, data_i, data_en, op.
//    Also set idx=0 and go to ISSUE. If both enables are high, it is a write.
//  - ISSUE: drive word-side signals for slice idx, combinationally from the captured registers.
//    - Write whose slice enable is 4'h0: no word enable, advance idx after 1 cycle.
//    - Otherwise hold word_*_en until word_done is sampled high. On a read, store word_data_o
//      into buffer slice idx at that edge.
//    - After slice WORDS-1 completes, go to RESP. Otherwise idx++.
//  - RESP: line_done=line_hit=1 for exactly one cycle, then IDLE.
//  - line_data_o = buffer. Stable from RESP until the next read's first word store.
//    Writes do not modify the buffer.
//  - Only one word access is in flight. word_addr and word enables never change while waiting.
//  - Line inputs are sampled only in IDLE. Changes mid-transaction are ignored.
//  - Requester must drop its enables the cycle after line_done. An enable seen in IDLE is a new
//    request. Minimum gap between dones is 1 IDLE cycle.
//  - Latency, zero-wait memory (word_done same cycle): request sampled at edge 0, ISSUE occupies
//    cycles 1..WORDS, line_done in cycle WORDS+1. Each word-side wait cycle adds 1.
//  - idx width $clog2(WORDS); final slice detected by idx==WORDS-1, with no wrap past the line.
//  - Reset mid-transaction: word enables drop asynchronously. The pending line request is
//    abandoned with no line_done. The requester must reissue it.
//  - Elaboration assertions: LINE_BYTES power of two and >= 8.
// TESTING
//  1 LINE_BYTES=16, zero-wait mem, read 0x1234_5678 -> word_addr 0x..70,74,78,7C in cycles 1-4,
//    line_done in cycle 5 only, line_data_o = {w3,w2,w1,w0}.
//  2 Write to 0x100, data_en=16'h00F0 -> exactly one word write: addr 0x104, data_en 4'hF.
//    line_done in cycle 5. Write with data_en=0 -> no word enables, line_done in cycle 5.
//  3 Memory with 2 wait cycles per word, read -> each word_addr held 3 cycles; line_done in cycle 13.
//  4 Both enables high -> write performed. Line inputs changed during ISSUE -> word outputs unchanged.
//  5 reset=0 in cycle 2 of a read -> word_read_en=0 and line_done=0 that cycle, buffer 0.
//    Next request after release completes normally.
//  6 Back-to-back reads, enables dropped after done -> second request sampled in IDLE.
//    Old line_data_o holds until the second read's first word store.

Source files
------------

// File: rtl/line_to_word_serializer.sv
// Splits one line request into LINE_BYTES/4 sequential word accesses and reassembles read words.
// Latency WORDS+1 cycles with zero-wait memory; requester holds its enables until line_done.
module line_to_word_serializer #(
  parameter int LINE_BYTES   = 64,
  parameter int ADDRESS_SIZE = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDRESS_SIZE-1:0]   line_addr,
  input  logic [8*LINE_BYTES-1:0]   line_data_i,
  input  logic [LINE_BYTES-1:0]     line_data_en,
  input  logic                      line_read_en,
  input  logic                      line_write_en,
  output logic [8*LINE_BYTES-1:0]   line_data_o,
  output logic                      line_hit,
  output logic                      line_done,
  output logic [ADDRESS_SIZE-1:0]   word_addr,
  output logic [31:0]               word_data_i,
  output logic [3:0]                word_data_en,
  output logic                      word_read_en,
  output logic                      word_write_en,
  input  logic [31:0]               word_data_o,
  input  logic                      word_done
);

  localparam int WORDS = LINE_BYTES / 4;
  localparam int IDXW  = $clog2(WORDS);
  localparam int OFFW  = $clog2(LINE_BYTES);

  if ((LINE_BYTES < 8) || ((LINE_BYTES & (LINE_BYTES - 1)) != 0)) begin : g_bad_line_bytes
    $error("LINE_BYTES must be a power of two and at least 8");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                    state_q, state_d;
  logic [IDXW-1:0]           idx_q, idx_d;
  logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
  logic [8*LINE_BYTES-1:0]   data_q, data_d;
  logic [LINE_BYTES-1:0]     en_q, en_d;
  logic                      wr_q, wr_d;
  logic [8*LINE_BYTES-1:0]   buf_q, buf_d;
  logic [3:0]                slice_en;
  logic                      skip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= '0;
      wr_q    <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      buf_q   <= buf_d;
    end
  end

  assign slice_en = en_q[idx_q*4 +: 4];
  // A write slice with no byte enables is skipped without touching the memory.
  assign skip     = wr_q && (slice_en == 4'h0);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    data_d        = data_q;
    en_d          = en_q;
    wr_d          = wr_q;
    buf_d         = buf_q;
    line_done     = 1'b0;
    word_addr     = '0;
    word_data_i   = '0;
    word_data_en  = 4'h0;
    word_read_en  = 1'b0;
    word_write_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_read_en || line_write_en) begin
          addr_d  = {line_addr[ADDRESS_SIZE-1:OFFW], {OFFW{1'b0}}};
          data_d  = line_data_i;
          en_d    = line_data_en;
          wr_d    = line_write_en;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        word_addr     = addr_q | ADDRESS_SIZE'({idx_q, 2'b00});
        word_data_i   = data_q[idx_q*32 +: 32];
        word_data_en  = wr_q ? slice_en : 4'hF;
        word_read_en  = !wr_q;
        word_write_en = wr_q && !skip;
        if (skip || word_done) begin
          if (!wr_q) begin
            buf_d[idx_q*32 +: 32] = word_data_o;
          end
          if (idx_q == IDXW'(WORDS - 1)) begin
            state_d = RESP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RESP: begin
        line_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign line_hit    = line_done;
  assign line_data_o = buf_q;

endmodule

// File: tb/tb_line_to_word_serializer.sv
// Directed bench for line_to_word_serializer with a 16-byte line and a wait-programmable word memory.
module tb_line_to_word_serializer;
  localparam int LB = 16;
  localparam int AS = 32;
  localparam int W  = LB / 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [AS-1:0]    line_addr;
  logic [8*LB-1:0]  line_data_i;
  logic [LB-1:0]    line_data_en;
  logic             line_read_en, line_write_en;
  logic [8*LB-1:0]  line_data_o;
  logic             line_hit, line_done;
  logic [AS-1:0]    word_addr;
  logic [31:0]      word_data_i;
  logic [3:0]       word_data_en;
  logic             word_read_en, word_write_en;
  logic [31:0]      word_data_o;
  logic             word_done;

  line_to_word_serializer #(.LINE_BYTES(LB), .ADDRESS_SIZE(AS)) dut (
    .clk(clk), .reset(reset),
    .line_addr(line_addr), .line_data_i(line_data_i), .line_data_en(line_data_en),
    .line_read_en(line_read_en), .line_write_en(line_write_en),
    .line_data_o(line_data_o), .line_hit(line_hit), .line_done(line_done),
    .word_addr(word_addr), .word_data_i(word_data_i), .word_data_en(word_data_en),
    .word_read_en(word_read_en), .word_write_en(word_write_en),
    .word_data_o(word_data_o), .word_done(word_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdfn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Word memory: completes after 'waits' extra cycles, read data is a function of the address.
  int waits = 0;
  int wcnt;
  assign word_done   = (word_read_en || word_write_en) && (wcnt >= waits);
  assign word_data_o = rdfn(word_addr);
  always @(posedge clk or negedge reset) begin
    if (!reset) wcnt <= 0;
    else if ((word_read_en || word_write_en) && !word_done) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [3:0]  en;
    logic [31:0] data;
  } acc_t;
  acc_t log_q[$];

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  en;
    int           waits;
    bit           scr;
    int           exp_done;
    int           exp_nacc;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] last_line = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_req();
    line_read_en  = 1'b0;
    line_write_en = 1'b0;
  endtask

  task automatic run_line(input vec_t v, input bit chk_hold, input logic [127:0] hold_line);
    int cyc, k, ndist;
    bit seen;
    logic [31:0] base;
    logic [3:0] e;
    logic [127:0] exp_line;
    base = {v.addr[31:4], 4'h0};
    log_q.delete();
    waits = v.waits;
    @(posedge clk); #1;
    line_addr = v.addr; line_data_i = v.data; line_data_en = v.en;
    line_read_en = v.rd; line_write_en = v.wr;
    cyc = 0; seen = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk); cyc++;
      if (cyc == 1 && v.scr) begin
        #1; line_addr = ~v.addr; line_data_i = ~v.data; line_data_en = ~v.en;
      end
      @(negedge clk);
      if (word_read_en || word_write_en)
        log_q.push_back('{word_addr, word_read_en, word_write_en, word_data_en, word_data_i});
      if (chk_hold && cyc <= v.waits + 1) chk("hold_old_line", line_data_o, hold_line);
      if (chk_hold && cyc == v.waits + 2) chk("first_store", {96'h0, line_data_o[31:0]}, {96'h0, rdfn(base)});
      if (line_done) seen = 1;
    end
    chk("done_cycle", cyc, v.exp_done);
    chk("line_hit", {127'h0, line_hit}, 128'h1);
    @(posedge clk); #1;
    drop_req();
    @(negedge clk);
    chk("done_one_cycle", {126'h0, line_done, line_hit}, 128'h0);
    k = 0;
    for (int i = 0; i < W; i++) begin
      e = v.en[4*i +: 4];
      if (v.wr && e == 4'h0) continue;
      for (int r = 0; r <= v.waits; r++) begin
        if (k < log_q.size()) begin
          chk("word_addr", log_q[k].addr, base + 32'(4*i));
          chk("word_rw", {126'h0, log_q[k].re, log_q[k].we}, {126'h0, !v.wr, v.wr});
          chk("word_data_en", log_q[k].en, v.wr ? e : 4'hF);
          if (v.wr) chk("word_data_i", log_q[k].data, v.data[32*i +: 32]);
        end
        k++;
      end
    end
    chk("access_cycles", log_q.size(), k);
    ndist = 0;
    for (int j = 0; j < log_q.size(); j++)
      if (j == 0 || log_q[j].addr != log_q[j-1].addr) ndist++;
    chk("word_accesses", ndist, v.exp_nacc);
    if (v.wr) begin
      chk("write_keeps_buf", line_data_o, last_line);
    end else begin
      for (int i = 0; i < W; i++) exp_line[32*i +: 32] = rdfn(base + 32'(4*i));
      chk("read_line", line_data_o, exp_line);
      last_line = exp_line;
    end
  endtask

  vec_t vt[6];
  vec_t v;

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h1234_5678, 128'h0, 16'h0000, 0, 1'b0, 5, 4};
    vt[1] = '{1'b0, 1'b1, 32'h0000_0100, 128'h3333_3333_2222_2222_DEAD_BEEF_1111_1111, 16'h00F0, 0, 1'b0, 5, 1};
    vt[2] = '{1'b0, 1'b1, 32'h0000_0200, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'h0000, 0, 1'b0, 5, 0};
    vt[3] = '{1'b1, 1'b0, 32'h0000_0040, 128'h0, 16'h0000, 2, 1'b0, 13, 4};
    vt[4] = '{1'b1, 1'b1, 32'h0000_0300, 128'hA0A1_A2A3_B0B1_B2B3_C0C1_C2C3_D0D1_D2D3, 16'hF00F, 1, 1'b1, 7, 2};
    vt[5] = '{1'b0, 1'b1, 32'h0000_0008, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hFFFF, 0, 1'b0, 5, 4};

    reset = 1'b0;
    line_addr = '0; line_data_i = '0; line_data_en = '0;
    line_read_en = 1'b0; line_write_en = 1'b0;
    #12;
    chk("rst_outputs", {123'h0, line_done, line_hit, word_read_en, word_write_en, 1'b0}, 128'h0);
    chk("rst_line_data", line_data_o, 128'h0);
    chk("rst_word_addr", word_addr, 32'h0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 6; i++) run_line(vt[i], 1'b0, '0);

    // Reset in the second cycle of a read: abandon it, then a fresh read completes normally.
    waits = 0;
    @(posedge clk); #1;
    line_addr = 32'h0000_0500; line_read_en = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_pre_rd_en", {127'h0, word_read_en}, 128'h1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_rd_en", {127'h0, word_read_en}, 128'h0);
    chk("mid_rst_done", {127'h0, line_done}, 128'h0);
    chk("mid_rst_buf", line_data_o, 128'h0);
    drop_req();
    last_line = '0;
    @(negedge clk); reset = 1'b1;
    v = '{1'b1, 1'b0, 32'h0000_0500, 128'h0, 16'h0, 0, 1'b0, 5, 4};
    run_line(v, 1'b0, '0);

    // Back-to-back reads: the previous line must persist until the new first word lands.
    v = '{1'b1, 1'b0, 32'h0000_0A00, 128'h0, 16'h0, 0, 1'b0, 5, 4};
    run_line(v, 1'b0, '0);
    v = '{1'b1, 1'b0, 32'h0000_0B10, 128'h0, 16'h0, 2, 1'b0, 13, 4};
    run_line(v, 1'b1, last_line);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
